// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for a 5-stage in-order pipeline
// (IF/ID/EX/MEM/WB) with 8 architectural registers.
//
// The block keeps a small record {valid, rd, wr_en, is_load} for each
// in-flight instruction downstream of ID. From these records it does three
// things:
//   * works out the EX-stage operand mux selects while the consumer is still
//     in ID, and registers them as the consumer moves into EX;
//   * raises a combinational stall when a load in EX feeds the instruction
//     in ID;
//   * counts stall cycles in a saturating counter for debug.
//
// Ports
//   clk          pipeline clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   id_valid     ID holds a real instruction
//   id_rs1       source register A index
//   id_rs2       source register B index
//   id_rs1_used  operand A reads id_rs1
//   id_rs2_used  operand B reads id_rs2
//   id_a_pc      operand A is the PC (overrides forwarding)
//   id_b_imm     operand B is the immediate (overrides forwarding)
//   id_rd        destination register index
//   id_wr_en     instruction writes id_rd
//   id_is_load   instruction is a load (result usable only from WB)
//   flush        branch redirect, the ID instruction is discarded this cycle
//   stall        hold PC and IF/ID, insert a bubble into EX (combinational)
//   ex_valid     EX holds a real instruction (registered)
//   fwd_a_sel    operand A select: 00 regfile, 01 MEM ALU, 10 WB, 11 PC
//   fwd_b_sel    operand B select: 00 regfile, 01 MEM ALU, 10 WB, 11 imm
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic [2:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    // Select encodings for the EX operand muxes.
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_OVR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Per-stage bookkeeping for one in-flight instruction.
    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
        logic       wr_en;
        logic       is_load;
    } stage_t;

    // A register index produced by a stage record. Index 0 is never a match
    // when it is hardwired to zero, so reads of r0 always come from the
    // regfile and never stall.
    function automatic logic stage_match(input stage_t s, input logic [2:0] rs);
        logic zero_hit;
        zero_hit = ZERO_REG_EN && (rs == 3'd0);
        return s.valid && s.wr_en && (s.rd == rs) && !zero_hit;
    endfunction

    // -------------------------------------------------------------------------
    // Stage records
    //
    // Only EX and MEM need storage here. By the time a producer reaches WB the
    // consumer that cares about it has already captured select 10 (it did so
    // while the producer was in MEM), and distance-3 consumers read the
    // regfile, which writes before it reads. A WB record would therefore have
    // no reader.
    // -------------------------------------------------------------------------
    stage_t ex_reg;
    stage_t mem_reg;
    stage_t ex_next;
    stage_t id_rec;

    logic   ex_load;

    assign id_rec = '{valid:   1'b1,
                      rd:      id_rd,
                      wr_en:   id_wr_en,
                      is_load: id_is_load};

    // -------------------------------------------------------------------------
    // Load-use detection
    //
    // A load in EX cannot feed ID in time: its data appears at the end of MEM.
    // Holding the consumer for one cycle puts the load in WB when the consumer
    // reaches EX, which the WB select covers. A flush discards the consumer,
    // so there is nothing to protect and no stall is needed. During reset the
    // records are being cleared, so the stall is held low to keep it defined
    // from the very first cycle.
    // -------------------------------------------------------------------------
    logic rs1_hit_ex;
    logic rs2_hit_ex;
    logic load_use;

    assign rs1_hit_ex = id_rs1_used && stage_match(ex_reg, id_rs1);
    assign rs2_hit_ex = id_rs2_used && stage_match(ex_reg, id_rs2);

    assign load_use = ex_reg.valid && ex_reg.is_load && (rs1_hit_ex || rs2_hit_ex);
    assign stall    = !rst && id_valid && !flush && load_use;

    // ID moves into EX only when it holds a real instruction that is neither
    // held back nor discarded; every other cycle EX takes a bubble.
    assign ex_load = id_valid && !stall && !flush;
    assign ex_next = ex_load ? id_rec : stage_t'('0);

    // -------------------------------------------------------------------------
    // Operand select generation
    //
    // Both operands use the same priority, so they share one generate body.
    // Operand 0 is A (override = PC), operand 1 is B (override = immediate).
    //   override            -> 11
    //   producer now in EX  -> 01 (it will be in MEM next cycle)
    //   producer now in MEM -> 10 (it will be in WB next cycle)
    //   otherwise           -> 00
    // The EX check sits above the MEM check so the youngest producer wins when
    // two in-flight instructions write the same register. A load in EX never
    // reaches the 01 arm in practice: that case stalls and the consumer is
    // re-evaluated a cycle later against MEM instead.
    // -------------------------------------------------------------------------
    logic [2:0] op_rs      [2];
    logic       op_used    [2];
    logic       op_ovr     [2];
    logic       op_hit_ex  [2];
    logic       op_hit_mem [2];
    logic [1:0] sel_next   [2];
    logic [1:0] sel_reg    [2];

    assign op_rs[0]   = id_rs1;
    assign op_rs[1]   = id_rs2;
    assign op_used[0] = id_rs1_used;
    assign op_used[1] = id_rs2_used;
    assign op_ovr[0]  = id_a_pc;
    assign op_ovr[1]  = id_b_imm;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign op_hit_ex[gi]  = op_used[gi] && stage_match(ex_reg,  op_rs[gi]);
            assign op_hit_mem[gi] = op_used[gi] && stage_match(mem_reg, op_rs[gi]);

            assign sel_next[gi] = op_ovr[gi]     ? SEL_OVR :
                                  op_hit_ex[gi]  ? SEL_MEM :
                                  op_hit_mem[gi] ? SEL_WB  :
                                                   SEL_RF;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pipeline state, registered selects and stall counter
    //
    // MEM and WB advance every cycle regardless of the stall: the stall only
    // freezes the front of the pipe, while the bubble it inserts flows on.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg        <= '0;
            mem_reg       <= '0;
            stall_cnt_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                sel_reg[i] <= SEL_RF;
            end
        end else begin
            mem_reg <= ex_reg;
            ex_reg  <= ex_next;

            // A bubble entering EX carries neutral selects.
            for (int i = 0; i < 2; i++) begin
                sel_reg[i] <= ex_load ? sel_next[i] : SEL_RF;
            end

            if (stall && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign ex_valid  = ex_reg.valid;
    assign fwd_a_sel = sel_reg[0];
    assign fwd_b_sel = sel_reg[1];
    assign stall_cnt = stall_cnt_reg;

endmodule
